asrv32_mem_arbiter: RTL and testbench
=====================================

// Module: asrv32_mem_arbiter
// PURPOSE
//  Shares one single-port synchronous-read RAM between the core's instruction-fetch port and its load/store port.
//  Sits between asrv32_core and the unified instruction/data memory of the SoC.
//  Grants one access per cycle and returns read data one cycle after the grant.
//  Data port has priority, with a starvation guard so instruction fetch always makes progress.
// PARAMETERS
//  MEMORY_DEPTH  1024  memory size in bytes; AW = $clog2(MEMORY_DEPTH), RAM word address = AW-2 bits
//  MAX_WAIT      4     consecutive denied fetch cycles (1..15) before fetch is forced ahead of data
// PORTS
//  i_clk        in   1    system clock
//  i_rst        in   1    synchronous, active-high reset
//  i_ireq       in   1    fetch request (read only)
//  i_iaddr      in   AW   fetch byte address
//  o_igrant     out  1    fetch accepted this cycle (combinational)
//  o_ivalid     out  1    fetch data valid (registered, 1 cycle after o_igrant)
//  o_idata      out  32   fetch data
//  i_dreq       in   1    data request
//  i_dwe        in   1    1 = store, 0 = load
//  i_dmask      in   4    byte write mask (stores only)
//  i_daddr      in   AW   data byte address
//  i_dwdata     in   32   store data
//  o_dgrant     out  1    data access accepted this cycle (combinational)
//  o_dvalid     out  1    load data valid / store complete (registered, 1 cycle after o_dgrant)
//  o_ddata      out  32   load data
//  o_mem_en     out  1    RAM access strobe
//  o_mem_we     out  1    RAM write enable
//  o_mem_mask   out  4    RAM byte mask
//  o_mem_addr   out  AW-2 RAM word address, taken as addr[AW-1:2]; addr[1:0] ignored
//  o_mem_wdata  out  32   RAM write data
//  i_mem_rdata  in   32   RAM read data, valid the cycle after o_mem_en with o_mem_we=0
// BEHAVIOUR
//  - One clock. While i_rst=1 the block clears:
//    o_ivalid=0, o_dvalid=0, owner=IDLE, starve count=0.
//  - Outputs forced during i_rst=1: o_igrant=o_dgrant=o_mem_en=o_mem_we=0, o_mem_mask=0.
//  - Arbitration, combinational each cycle:
//    * force_i = (cnt == MAX_WAIT);
//    * grant D if i_dreq && !(force_i && i_ireq), else grant I if i_ireq;
//    * at most one grant per cycle.
//  - Memory drive follows the winner.
//    * D wins: en=1, we=i_dwe, mask = i_dwe ? i_dmask : 0, addr = i_daddr[AW-1:2], wdata = i_dwdata.
//    * I wins: en=1, we=0, mask=0, addr = i_iaddr[AW-1:2].
//    * No winner: en=0, we=0, mask=0; addr/wdata are don't-care.
//  - Starve counter, 4-bit register:
//    * clears when !i_ireq or o_igrant;
//    * increments when i_ireq && !o_igrant;
//    * saturates at MAX_WAIT.
//  - Response owner FSM: IDLE / RESP_I / RESP_D, registered each cycle from the grant (RESP_D for both loads and stores).
//    * RESP_I: o_ivalid=1, o_idata=i_mem_rdata.
//    * RESP_D: o_dvalid=1, o_ddata = load ? i_mem_rdata : 0.
//    * Non-owner data outputs drive 0.
//  - Fully pipelined. A new grant is allowed every cycle while the previous response returns. Requesters may hold req; each held cycle that is granted is a new access.
//  - Requesters must hold address/data stable only in the cycle their grant is high; nothing is latched before the grant.
//  - Simultaneous I and D requests, no force: D granted, I counter increments.
//  - Simultaneous requests with force: I granted, counter clears, D waits one cycle.
//  - Store then load to the same word in back-to-back cycles: the load returns the new data (RAM write-first at the clock edge).
//  - Reset mid-operation: a grant issued in the cycle before reset produces no valid after reset. The owner FSM returns to IDLE, so no stale valid appears.
// STRUCTURE
//  - asrv32_header.vh gains:
//    * owner encodings ARB_IDLE=2'd0, ARB_RESP_I=2'd1, ARB_RESP_D=2'd2;
//    * the starve counter width.
//  - Sub-module asrv32_starve_guard: holds the saturating counter and produces force_i from (i_ireq, o_igrant); parameter MAX_WAIT.
//  - Everything else (priority mux, memory drive, owner FSM, response muxing) lives in the top module.
// TESTING
//  - Reset: hold i_rst=1 three cycles with both reqs high:
//    * no grants, o_mem_en=0, valids 0;
//    * first cycle after release: D granted.
//  - Fetch-only:
//    * stimulus: i_ireq=1 at addr 0x10, RAM word 4 = 0x00500093;
//    * o_igrant same cycle, o_mem_addr=4;
//    * next cycle o_ivalid=1, o_idata=0x00500093.
//  - Store + load:
//    * stimulus: store 0xDEADBEEF mask 4'b0011 to 0x20 (old 0x11223344), then load 0x20;
//    * o_ddata=0x1122BEEF with o_dvalid on the cycle after the load grant;
//    * the store's o_dvalid cycle shows o_ddata=0.
//  - Starvation, MAX_WAIT=4, both reqs held high:
//    * grant pattern is D,D,D,D,I repeating;
//    * counter never exceeds 4.
//  - Back-to-back alternating I/D grants:
//    * each valid lands on the correct port exactly one cycle after its grant;
//    * o_idata/o_ddata are 0 on non-owned cycles.
//  - Assert i_rst in the cycle after a load grant: o_dvalid stays 0, FSM=IDLE.

Source files
------------

// File: rtl/asrv32_mem_arbiter_pkg.sv
// rtl/asrv32_mem_arbiter_pkg.sv - shared types and constants for the memory arbiter
package asrv32_mem_arbiter_pkg;

    // Width of the fetch starvation counter; holds MAX_WAIT values up to 15.
    localparam int STARVE_CW = 4;

    // Which port owns the read data returning from the RAM this cycle.
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_RESP_I = 2'd1,
        ARB_RESP_D = 2'd2
    } arb_owner_e;

endpackage

// File: rtl/asrv32_starve_guard.sv
// rtl/asrv32_starve_guard.sv - saturating count of denied fetch cycles, raises force_i at MAX_WAIT
module asrv32_starve_guard
    import asrv32_mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_ireq,
    input  logic i_igrant,
    output logic o_force_i
);

    localparam logic [STARVE_CW-1:0] MAX_CNT = STARVE_CW'(MAX_WAIT);

    logic [STARVE_CW-1:0] cnt_q;
    logic [STARVE_CW-1:0] cnt_d;

    assign o_force_i = (cnt_q == MAX_CNT);

    // Count consecutive denied fetch cycles; any grant or dropped request restarts the count.
    always_comb begin
        cnt_d = cnt_q;
        if (!i_ireq || i_igrant) begin
            cnt_d = '0;
        end else if (cnt_q != MAX_CNT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/asrv32_mem_arbiter.sv
// rtl/asrv32_mem_arbiter.sv - shares one single-port RAM between fetch and load/store ports
module asrv32_mem_arbiter
    import asrv32_mem_arbiter_pkg::*;
#(
    parameter int MEMORY_DEPTH = 1024,
    parameter int MAX_WAIT     = 4,
    localparam int AW          = $clog2(MEMORY_DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_ireq,
    input  logic [AW-1:0] i_iaddr,
    output logic          o_igrant,
    output logic          o_ivalid,
    output logic [31:0]   o_idata,
    input  logic          i_dreq,
    input  logic          i_dwe,
    input  logic [3:0]    i_dmask,
    input  logic [AW-1:0] i_daddr,
    input  logic [31:0]   i_dwdata,
    output logic          o_dgrant,
    output logic          o_dvalid,
    output logic [31:0]   o_ddata,
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [3:0]    o_mem_mask,
    output logic [AW-3:0] o_mem_addr,
    output logic [31:0]   o_mem_wdata,
    input  logic [31:0]   i_mem_rdata
);

    logic       force_i;
    logic       grant_i;
    logic       grant_d;
    arb_owner_e owner_q;
    arb_owner_e owner_d;
    logic       d_load_q;
    logic       d_load_d;

    // Byte-lane bits of the addresses are never used by a word-wide RAM.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{i_iaddr[1:0], i_daddr[1:0]};

    asrv32_starve_guard #(
        .MAX_WAIT (MAX_WAIT)
    ) u_guard (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_ireq    (i_ireq),
        .i_igrant  (grant_i),
        .o_force_i (force_i)
    );

    // Data port wins unless fetch has waited long enough to be forced ahead; nothing granted in reset.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (!i_rst) begin
            if (i_dreq && !(force_i && i_ireq)) begin
                grant_d = 1'b1;
            end else if (i_ireq) begin
                grant_i = 1'b1;
            end
        end
    end

    assign o_igrant = grant_i;
    assign o_dgrant = grant_d;

    // RAM strobe, write controls and address follow whichever port won.
    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_mask  = 4'b0000;
        o_mem_addr  = i_daddr[AW-1:2];
        o_mem_wdata = i_dwdata;
        if (grant_d) begin
            o_mem_en   = 1'b1;
            o_mem_we   = i_dwe;
            o_mem_mask = i_dwe ? i_dmask : 4'b0000;
        end else if (grant_i) begin
            o_mem_en   = 1'b1;
            o_mem_addr = i_iaddr[AW-1:2];
        end
    end

    // Next response owner is decided by this cycle's grant; loads are remembered to gate o_ddata.
    always_comb begin
        owner_d  = ARB_IDLE;
        d_load_d = 1'b0;
        if (grant_d) begin
            owner_d  = ARB_RESP_D;
            d_load_d = !i_dwe;
        end else if (grant_i) begin
            owner_d = ARB_RESP_I;
        end
    end

    // Owner state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            owner_q  <= ARB_IDLE;
            d_load_q <= 1'b0;
        end else begin
            owner_q  <= owner_d;
            d_load_q <= d_load_d;
        end
    end

    // Steer returning RAM data to its owner; a response in flight when reset arrives is dropped.
    always_comb begin
        o_ivalid = 1'b0;
        o_idata  = 32'h0;
        o_dvalid = 1'b0;
        o_ddata  = 32'h0;
        if (!i_rst) begin
            if (owner_q == ARB_RESP_I) begin
                o_ivalid = 1'b1;
                o_idata  = i_mem_rdata;
            end else if (owner_q == ARB_RESP_D) begin
                o_dvalid = 1'b1;
                o_ddata  = d_load_q ? i_mem_rdata : 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_asrv32_mem_arbiter.sv
// tb/tb_asrv32_mem_arbiter.sv - directed vector bench for the memory arbiter
module tb_asrv32_mem_arbiter;
    import asrv32_mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ireq;
    logic [9:0]  iaddr;
    logic        igrant, ivalid;
    logic [31:0] idata;
    logic        dreq, dwe;
    logic [3:0]  dmask;
    logic [9:0]  daddr;
    logic [31:0] dwdata;
    logic        dgrant, dvalid;
    logic [31:0] ddata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_mask;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    asrv32_mem_arbiter #(.MEMORY_DEPTH(1024), .MAX_WAIT(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_ireq(ireq), .i_iaddr(iaddr), .o_igrant(igrant), .o_ivalid(ivalid), .o_idata(idata),
        .i_dreq(dreq), .i_dwe(dwe), .i_dmask(dmask), .i_daddr(daddr), .i_dwdata(dwdata),
        .o_dgrant(dgrant), .o_dvalid(dvalid), .o_ddata(ddata),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_mask(mem_mask), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    // Behavioural single-port synchronous RAM with byte-masked writes.
    logic [31:0] ram [256];
    initial begin
        for (int k = 0; k < 256; k++) ram[k] = 32'hA500_0000 | k;
        ram[4] = 32'h0050_0093;
        ram[8] = 32'h1122_3344;
    end
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_mask[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        rst;
        logic        ireq;
        logic [9:0]  iaddr;
        logic        dreq;
        logic        dwe;
        logic [3:0]  dmask;
        logic [9:0]  daddr;
        logic [31:0] dwdata;
        logic        e_ig;
        logic        e_dg;
        logic        e_en;
        logic        e_we;
        logic [3:0]  e_mask;
        logic        chk_addr;
        logic [7:0]  e_addr;
        logic        e_iv;
        logic        e_dv;
        logic [31:0] e_id;
        logic [31:0] e_dd;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic drive(input logic r, input logic ir, input logic [9:0] ia,
                         input logic dr, input logic we, input logic [3:0] m,
                         input logic [9:0] da, input logic [31:0] wd);
        @(negedge clk);
        rst = r; ireq = ir; iaddr = ia; dreq = dr; dwe = we; dmask = m; daddr = da; dwdata = wd;
        #1;
    endtask

    initial begin
        rst = 1'b1; ireq = 1'b0; iaddr = '0; dreq = 1'b0; dwe = 1'b0;
        dmask = '0; daddr = '0; dwdata = '0;

        //          rst ireq iaddr  dreq dwe dmask   daddr   dwdata        ig dg en we mask   ca addr iv dv idata          ddata
        vecs[0]  = '{1'b1,1'b1,10'h010,1'b1,1'b0,4'h0,10'h040,32'h0,        1'b0,1'b0,1'b0,1'b0,4'h0,1'b0,8'd0, 1'b0,1'b0,32'h0,32'h0};
        vecs[1]  = '{1'b1,1'b1,10'h010,1'b1,1'b0,4'h0,10'h040,32'h0,        1'b0,1'b0,1'b0,1'b0,4'h0,1'b0,8'd0, 1'b0,1'b0,32'h0,32'h0};
        vecs[2]  = '{1'b1,1'b1,10'h010,1'b1,1'b0,4'h0,10'h040,32'h0,        1'b0,1'b0,1'b0,1'b0,4'h0,1'b0,8'd0, 1'b0,1'b0,32'h0,32'h0};
        vecs[3]  = '{1'b0,1'b1,10'h010,1'b1,1'b0,4'h0,10'h040,32'h0,        1'b0,1'b1,1'b1,1'b0,4'h0,1'b1,8'd16,1'b0,1'b0,32'h0,32'h0};
        vecs[4]  = '{1'b0,1'b1,10'h010,1'b0,1'b0,4'h0,10'h000,32'h0,        1'b1,1'b0,1'b1,1'b0,4'h0,1'b1,8'd4, 1'b0,1'b1,32'h0,32'hA500_0010};
        vecs[5]  = '{1'b0,1'b0,10'h000,1'b0,1'b0,4'h0,10'h000,32'h0,        1'b0,1'b0,1'b0,1'b0,4'h0,1'b0,8'd0, 1'b1,1'b0,32'h0050_0093,32'h0};
        vecs[6]  = '{1'b0,1'b0,10'h000,1'b1,1'b1,4'h3,10'h020,32'hDEADBEEF, 1'b0,1'b1,1'b1,1'b1,4'h3,1'b1,8'd8, 1'b0,1'b0,32'h0,32'h0};
        vecs[7]  = '{1'b0,1'b0,10'h000,1'b1,1'b0,4'hF,10'h022,32'h0,        1'b0,1'b1,1'b1,1'b0,4'h0,1'b1,8'd8, 1'b0,1'b1,32'h0,32'h0};
        vecs[8]  = '{1'b0,1'b0,10'h000,1'b0,1'b0,4'h0,10'h000,32'h0,        1'b0,1'b0,1'b0,1'b0,4'h0,1'b0,8'd0, 1'b0,1'b1,32'h0,32'h1122_BEEF};
        vecs[9]  = '{1'b0,1'b0,10'h000,1'b0,1'b0,4'h0,10'h000,32'h0,        1'b0,1'b0,1'b0,1'b0,4'h0,1'b0,8'd0, 1'b0,1'b0,32'h0,32'h0};
        vecs[10] = '{1'b0,1'b1,10'h013,1'b0,1'b0,4'h0,10'h000,32'h0,        1'b1,1'b0,1'b1,1'b0,4'h0,1'b1,8'd4, 1'b0,1'b0,32'h0,32'h0};
        vecs[11] = '{1'b0,1'b0,10'h000,1'b1,1'b0,4'h0,10'h020,32'h0,        1'b0,1'b1,1'b1,1'b0,4'h0,1'b1,8'd8, 1'b1,1'b0,32'h0050_0093,32'h0};
        vecs[12] = '{1'b0,1'b1,10'h014,1'b0,1'b0,4'h0,10'h000,32'h0,        1'b1,1'b0,1'b1,1'b0,4'h0,1'b1,8'd5, 1'b0,1'b1,32'h0,32'h1122_BEEF};
        vecs[13] = '{1'b0,1'b0,10'h000,1'b0,1'b0,4'h0,10'h000,32'h0,        1'b0,1'b0,1'b0,1'b0,4'h0,1'b0,8'd0, 1'b1,1'b0,32'hA500_0005,32'h0};

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].ireq, vecs[i].iaddr, vecs[i].dreq, vecs[i].dwe,
                  vecs[i].dmask, vecs[i].daddr, vecs[i].dwdata);
            chk($sformatf("v%0d igrant", i), {31'b0, igrant}, {31'b0, vecs[i].e_ig});
            chk($sformatf("v%0d dgrant", i), {31'b0, dgrant}, {31'b0, vecs[i].e_dg});
            chk($sformatf("v%0d mem_en", i), {31'b0, mem_en}, {31'b0, vecs[i].e_en});
            chk($sformatf("v%0d mem_we", i), {31'b0, mem_we}, {31'b0, vecs[i].e_we});
            chk($sformatf("v%0d mem_mask", i), {28'b0, mem_mask}, {28'b0, vecs[i].e_mask});
            if (vecs[i].chk_addr)
                chk($sformatf("v%0d mem_addr", i), {24'b0, mem_addr}, {24'b0, vecs[i].e_addr});
            if (vecs[i].e_we)
                chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].dwdata);
            chk($sformatf("v%0d ivalid", i), {31'b0, ivalid}, {31'b0, vecs[i].e_iv});
            chk($sformatf("v%0d dvalid", i), {31'b0, dvalid}, {31'b0, vecs[i].e_dv});
            chk($sformatf("v%0d idata", i), idata, vecs[i].e_id);
            chk($sformatf("v%0d ddata", i), ddata, vecs[i].e_dd);
        end

        // Both ports held requesting from an idle counter: D,D,D,D,I repeating.
        for (int c = 0; c < 10; c++) begin
            logic exp_i;
            exp_i = ((c % 5) == 4);
            drive(1'b0, 1'b1, 10'h010, 1'b1, 1'b0, 4'h0, 10'h040, 32'h0);
            chk($sformatf("starve c%0d igrant", c), {31'b0, igrant}, {31'b0, exp_i});
            chk($sformatf("starve c%0d dgrant", c), {31'b0, dgrant}, {31'b0, !exp_i});
            chk($sformatf("starve c%0d mem_addr", c), {24'b0, mem_addr}, exp_i ? 32'd4 : 32'd16);
            total++;
            if (dut.u_guard.cnt_q > 4'd4) begin
                bad++;
                $display("FAIL starve c%0d cnt actual=%0d required<=4", c, dut.u_guard.cnt_q);
            end
        end

        // Reset asserted the cycle after a load grant drops the pending response.
        drive(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
        drive(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 4'h0, 10'h020, 32'h0);
        chk("rstmid load grant", {31'b0, dgrant}, 32'd1);
        drive(1'b1, 1'b1, 10'h010, 1'b1, 1'b0, 4'h0, 10'h020, 32'h0);
        chk("rstmid dvalid in reset", {31'b0, dvalid}, 32'd0);
        chk("rstmid no grant in reset", {30'b0, igrant, dgrant}, 32'd0);
        chk("rstmid mem_en in reset", {31'b0, mem_en}, 32'd0);
        drive(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
        chk("rstmid dvalid after", {31'b0, dvalid}, 32'd0);
        chk("rstmid ddata after", ddata, 32'h0);
        chk("rstmid owner idle", {30'b0, dut.owner_q}, {30'b0, ARB_IDLE});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
